mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, byte-addressed, 16-bit unified memory between an instruction-fetch port (read-only) and a data port (read/write).
- Adds a programmable access latency to model a multi-cycle memory.
- Sits between the I/D cache fill logic and the memory: drives the memory's enable/wr/addr/data_in and returns data_out to the winning requester.

Parameters:
- ADDR_WIDTH, 16, width of all addresses; bit 0 is passed through unchanged.
- LATENCY, 4, cycles from accept to the memory strobe cycle; legal range ≥1.
- STARVE_LIMIT, 3, consecutive lost arbitrations before the I port is forced to win (only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request (level), held until i_done.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_done  out  1  one-cycle pulse; i_rdata valid in this cycle.
- i_rdata  out  16  fetch read data.
- d_req  in  1  data request (level), held until d_done.
- d_wr  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  16  write data.
- d_done  out  1  one-cycle pulse; d_rdata valid in this cycle (reads).
- d_rdata  out  16  data read data.
- busy  out  1  high in any state other than IDLE.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data (combinational from the memory).

Behaviour:
- Reset (async, active-high): state = IDLE, counter = 0, owner = D, starve count = 0, latched addr/wdata/wr = 0.
- Reset forces all outputs to 0 immediately.
- Reset mid-access abandons the transfer: no done pulse, no memory strobe.
- States: IDLE → ACCESS → DONE → IDLE.
- IDLE:
  - If d_req or i_req is high at the edge: latch owner, address, wr (forced 0 for I) and wdata; set counter = LATENCY-1; go to ACCESS.
  - Arbitration: D wins when both request; I wins when only i_req is high.
- ACCESS:
  - Counter decrements each cycle.
  - In the cycle with counter == 0: mem_enable = 1 and mem_wr = latched wr. On that edge: read data is captured into the owner's rdata register, or the memory performs the write. Then go to DONE.
  - mem_enable is high for exactly one cycle per transfer, so each write occurs exactly once.
- DONE:
  - Owner's done = 1 for one cycle. The non-owner's done stays 0.
  - Always returns to IDLE; no request is sampled in DONE.
  - Requesters drop req at the edge ending DONE, or re-issue a new request.
- Outputs:
  - mem_addr, mem_data_in and mem_wr come from the latched registers. mem_wr is gated by mem_enable.
  - Outside the strobe cycle: mem_enable = 0 and mem_wr = 0.
- Latency: request seen in IDLE at edge T; strobe cycle is T+LATENCY; done pulse is in cycle T+LATENCY+1. Back-to-back throughput is one transfer per LATENCY+2 cycles.
- i_rdata and d_rdata hold their last captured values until the next capture for the same port. Writes do not change d_rdata.
- Requests arriving while busy are not lost. Requesters hold req, and the request is sampled in the next IDLE.
- Input changes during ACCESS/DONE are ignored, because the transfer uses the latched values.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A 2-bit-or-wider starve counter increments each time I requests in IDLE but D wins, saturating at STARVE_LIMIT.
  - When the counter == STARVE_LIMIT and both ports request, I wins.
  - The counter clears whenever I is granted.
- Without the macro: strict D priority; I can starve indefinitely under continuous D traffic; no counter logic.

Test Plan:
- Reset then idle: rst=1 asynchronously mid-cycle → all outputs 0 at once. After release with no requests → mem_enable stays 0 and busy=0 for 10 cycles.
- D write then read (LATENCY=4): d_req=1, d_wr=1, d_addr=0x0010, d_wdata=0xBEEF at edge T → mem_enable=1, mem_wr=1 only in cycle T+4; d_done pulse in cycle T+5. Then a read of 0x0010 → d_rdata=0xBEEF with d_done; i_done stays 0 throughout.
- I fetch: preload memory word at 0x0100 = 0x1234; i_req=1, i_addr=0x0100 → mem_wr=0 in the strobe cycle; i_done and i_rdata=0x1234 five cycles after accept.
- Contention: i_req and d_req rise in the same IDLE cycle → D served first, with d_done at T+5. I accepted in the IDLE at T+6; i_done at T+11.
- Starvation: d_req held continuously with new requests after each d_done, i_req held.
  - With MEM_ARB_STARVE_GUARD_EN (STARVE_LIMIT=3): three D transfers, then I granted on the fourth arbitration.
  - Without the macro: no i_done in 50 cycles.
- Reset mid-access: assert rst during ACCESS with counter=2 → no strobe, no done pulse. After release, a fresh d_req completes normally with correct latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port 16-bit memory between a fetch port and a data port,
// adding LATENCY cycles per access. Optional I-port starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LATENCY      = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [15:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_done,
    output logic [15:0]           d_rdata,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ownerD;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_iRdata;
    logic [15:0]           r_dRdata;
    logic                  w_grantI;
    logic                  w_grantD;
    logic                  w_strobe;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] r_starve;

    // Once I has lost STARVE_LIMIT times in a row it beats a competing D request.
    always_comb begin
        w_grantI = 1'b0;
        w_grantD = 1'b0;
        if (i_req && (!d_req || r_starve == STARVE_MAX)) begin
            w_grantI = 1'b1;
        end else if (d_req) begin
            w_grantD = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (w_grantI) begin
                r_starve <= '0;
            end else if (w_grantD && i_req && r_starve != STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_grantI = 1'b0;
        w_grantD = 1'b0;
        if (d_req) begin
            w_grantD = 1'b1;
        end else if (i_req) begin
            w_grantI = 1'b1;
        end
    end
`endif

    assign w_strobe = (r_state == ACCESS) && (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_enable  = w_strobe;
        mem_wr      = w_strobe & r_wr;
        mem_addr    = r_addr;
        mem_data_in = r_wdata;
        busy        = (r_state != IDLE);
        i_done      = (r_state == DONE) && !r_ownerD;
        d_done      = (r_state == DONE) && r_ownerD;
        case (r_state)
            IDLE:    if (w_grantI || w_grantD) w_next = ACCESS;
            ACCESS:  if (w_strobe) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are latched at accept so later input changes cannot disturb the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_ownerD <= 1'b1;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_iRdata <= '0;
            r_dRdata <= '0;
        end else begin
            if (r_state == IDLE && (w_grantI || w_grantD)) begin
                r_ownerD <= w_grantD;
                r_addr   <= w_grantD ? d_addr : i_addr;
                r_wr     <= w_grantD & d_wr;
                r_wdata  <= w_grantD ? d_wdata : 16'h0000;
                r_count  <= CNT_LOAD;
            end else if (r_state == ACCESS && r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
            if (w_strobe && !r_wr) begin
                if (r_ownerD) begin
                    r_dRdata <= mem_data_out;
                end else begin
                    r_iRdata <= mem_data_out;
                end
            end
        end
    end

    assign i_rdata = r_iRdata;
    assign d_rdata = r_dRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (LATENCY=4, STARVE_LIMIT=3) with a
// behavioural word memory behind the arbiter.
module tb_mem_arbiter;
    localparam int AW  = 16;
    localparam int LAT = 4;

    typedef struct {
        bit          isD;
        bit          isWrite;
        logic [AW-1:0] addr;
        logic [15:0] data;
    } sbEntry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [15:0]   i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_done;
    logic [15:0]   d_rdata;
    logic          busy;
    logic          mem_enable;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data_in;
    logic [15:0]   mem_data_out;

    sbEntry_t    sb[$];
    logic [15:0] refMem [int];
    int          total = 0;
    int          bad = 0;

    logic [15:0] mem [0:255];
    logic        preloadEn = 1'b0;
    logic [7:0]  preloadIdx = 8'h00;
    logic [15:0] preloadData = 16'h0000;

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Byte-addressed 16-bit memory: word index is the address without bit 0.
    assign mem_data_out = mem[mem_addr[8:1]];

    always @(posedge clk) begin
        if (preloadEn) begin
            mem[preloadIdx] <= preloadData;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[8:1]] <= mem_data_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [15:0] data);
        @(negedge clk);
        preloadEn   = 1'b1;
        preloadIdx  = addr[8:1];
        preloadData = data;
        refMem[int'(addr[AW-1:1])] = data;
        @(negedge clk);
        preloadEn = 1'b0;
    endtask

    // Drives a request and records what the arbiter must eventually return for it.
    task automatic applyStimulus(input bit isD, input bit wr, input logic [AW-1:0] addr, input logic [15:0] wdata);
        sbEntry_t e;
        if (isD) begin
            d_req   = 1'b1;
            d_wr    = wr;
            d_addr  = addr;
            d_wdata = wdata;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        e.isD     = isD;
        e.isWrite = isD && wr;
        e.addr    = addr;
        if (e.isWrite) begin
            e.data = wdata;
            refMem[int'(addr[AW-1:1])] = wdata;
        end else if (refMem.exists(int'(addr[AW-1:1]))) begin
            e.data = refMem[int'(addr[AW-1:1])];
        end else begin
            e.data = 16'hxxxx;
        end
        sb.push_back(e);
    endtask

    // Counts falling edges from the call until a done pulse, checking the strobe on the way.
    task automatic waitDone(input string tag, input int expDone, input int expStrobe);
        sbEntry_t e;
        int k;
        int strobes;
        bit seen;
        k = 0;
        strobes = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (mem_enable) begin
                strobes++;
                checkOutput({tag, "_strobe_cycle"}, 32'(k), 32'(expStrobe));
                if (sb.size() > 0) begin
                    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(sb[0].addr));
                    checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'(sb[0].isWrite));
                    if (sb[0].isWrite) begin
                        checkOutput({tag, "_mem_data_in"}, 32'(mem_data_in), 32'(sb[0].data));
                    end
                end
            end
            if (i_done || d_done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checkOutput({tag, "_sb_empty"}, 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput({tag, "_latency"}, 32'(k), 32'(expDone));
                    checkOutput({tag, "_port"}, 32'({i_done, d_done}), e.isD ? 32'h1 : 32'h2);
                    if (!e.isWrite) begin
                        checkOutput({tag, "_rdata"}, e.isD ? 32'(d_rdata) : 32'(i_rdata), 32'(e.data));
                    end
                    checkOutput({tag, "_strobe_count"}, 32'(strobes), 32'(1));
                end
            end
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 32'(k), 32'(expDone));
        end
    endtask

    initial begin
        int strobes;
        int busyCount;
        int doneCount;
        logic anyOut;

        rst     = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        #1 rst = 1'b1;

        preload(16'h0100, 16'h1234);
        @(negedge clk);
        anyOut = |{busy, i_done, d_done, mem_enable, mem_wr, mem_addr, mem_data_in, i_rdata, d_rdata};
        checkOutput("reset_outputs", 32'(anyOut), 32'(0));
        rst = 1'b0;

        strobes = 0;
        busyCount = 0;
        repeat (10) begin
            @(negedge clk);
            strobes += int'(mem_enable);
            busyCount += int'(busy);
        end
        checkOutput("idle_strobes", 32'(strobes), 32'(0));
        checkOutput("idle_busy", 32'(busyCount), 32'(0));

        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        waitDone("d_write", LAT + 1, LAT);
        d_req = 1'b0;
        checkOutput("d_rdata_after_write", 32'(d_rdata), 32'(0));
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        waitDone("d_read", LAT + 1, LAT);
        d_req = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000);
        waitDone("i_fetch", LAT + 1, LAT);
        i_req = 1'b0;
        checkOutput("d_rdata_hold", 32'(d_rdata), 32'hBEEF);
        @(negedge clk);

        // Both ports request together: D first, then I in the next IDLE.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000);
        waitDone("cont_d", LAT + 1, LAT);
        d_req = 1'b0;
        waitDone("cont_i", LAT + 2, LAT + 1);
        i_req = 1'b0;
        @(negedge clk);

        i_req  = 1'b1;
        i_addr = 16'h0100;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b1, 16'(16'h0020 + 2 * n), 16'(16'hA000 + n));
            waitDone($sformatf("starve_d%0d", n), (n == 0) ? LAT + 1 : LAT + 2, (n == 0) ? LAT : LAT + 1);
        end
        applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h0026, 16'hA003);
        waitDone("starve_i_granted", LAT + 2, LAT + 1);
        i_req = 1'b0;
        waitDone("starve_d_after", LAT + 2, LAT + 1);
        d_req = 1'b0;
`else
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1'b1, 1'b1, 16'(16'h0020 + 2 * n), 16'(16'hA000 + n));
            waitDone($sformatf("starve_d%0d", n), (n == 0) ? LAT + 1 : LAT + 2, (n == 0) ? LAT : LAT + 1);
        end
        d_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000);
        waitDone("starve_i_late", LAT + 2, LAT + 1);
        i_req = 1'b0;
`endif
        @(negedge clk);

        // Abort a read while its counter sits at 2; nothing of it may surface afterwards.
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        anyOut = |{busy, i_done, d_done, mem_enable, mem_wr, mem_addr, mem_data_in, i_rdata, d_rdata};
        checkOutput("midreset_outputs", 32'(anyOut), 32'(0));
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        doneCount = 0;
        repeat (10) begin
            @(negedge clk);
            strobes += int'(mem_enable);
            doneCount += int'(i_done) + int'(d_done);
        end
        checkOutput("midreset_strobes", 32'(strobes), 32'(0));
        checkOutput("midreset_done", 32'(doneCount), 32'(0));

        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        waitDone("post_reset_read", LAT + 1, LAT);
        d_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
